count_seg7_display: RTL
=======================

COUNT_SEG7_DISPLAY -- requirements
Module: count_seg7_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, SHALL set the clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous and active-low.
REQ-004 count_in  input  4  SHALL carry the free-running 4-bit bit-counter value (0..15) from the upstream stage, same clock domain.
REQ-005 an  output  4  SHALL be the registered, active-low, one-hot digit anode enables; an[0] is the rightmost digit.
REQ-006 seg  output  7  SHALL be the registered, active-low cathodes, seg[6:0]=g,f,e,d,c,b,a.
REQ-007 dp  output  1  SHALL be the registered, active-low decimal point.

Function
REQ-008 count_in SHALL be registered into cnt_q every cycle; the previous cnt_q SHALL be held in cnt_prev.
REQ-009 A wrap event SHALL be flagged when cnt_prev==15 and cnt_q==0, one cycle after the second sample is registered.
REQ-010 Wrap event SHALL increment a 2-digit BCD wrap counter (wrap_tens, wrap_ones); 09->10, 99->00 roll-over, no saturation.
REQ-011 A non-wrap change (e.g. 15->14, 3->0) SHALL NOT increment the wrap counter.
REQ-012 cnt_q SHALL be split into decimal digits: tens=1 and ones=cnt_q-10 when cnt_q>=10, else tens=0 and ones=cnt_q.
REQ-013 Refresh divider div SHALL count 0..REFRESH_DIV-1 and wrap to 0; on the terminal value, digit index idx SHALL advance 0->1->2->3->0.
REQ-014 On the cycle idx advances from 3 to 0 (and on the first cycle after reset), a snapshot of {count tens, count ones, wrap_tens, wrap_ones} SHALL be latched; displayed digits SHALL come only from the snapshot (no tearing within a scan).
REQ-015 If a wrap increment and a snapshot occur on the same edge, the snapshot SHALL capture the pre-increment wrap value.
REQ-016 Digit mapping: idx0=count ones, idx1=count tens, idx2=wrap ones, idx3=wrap tens.
REQ-017 Leading-zero blanking: idx1 SHALL show blank (seg=1111111) when count tens is 0; idx3 SHALL show blank when wrap_tens is 0; anode still asserted.
REQ-018 Decode (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 an SHALL equal ~(4'b0001<<idx), registered, updating on the cycle after idx changes, together with seg and dp (1-cycle output latency from idx).
REQ-020 dp SHALL be 0 only while idx==2 (separator between count and wrap fields), else 1.
REQ-021 Exactly one an bit SHALL be low at any time outside reset.

Reset
REQ-022 While rst_n==0 at a clk edge: div=0, idx=0, cnt_q=0, cnt_prev=0, wrap counter=00, snapshot=all zero, an=1111, seg=1111111, dp=1.
REQ-023 Reset asserted mid-scan SHALL abandon the scan immediately; first edge after release SHALL take a snapshot and the following edge SHALL drive an=1110, seg=1000000.
REQ-024 Reset SHALL clear the wrap counter; no wrap SHALL be flagged from the 0 reset value of cnt_prev.

Verification (bench uses REFRESH_DIV=4)
REQ-025 Release reset with count_in=0 -> an sequence 1110,1101,1011,0111 each held 4 cycles; seg 1000000, blank, 1000000 with dp=0, blank.
REQ-026 count_in=13 held -> after next scan start idx0 seg=0110000 (3), idx1 seg=1111001 (1).
REQ-027 Drive count_in 14,15,0 on successive cycles, repeat 12 times -> wrap counter 12; next scan idx2 seg=0100100, idx3 seg=1111001.
REQ-028 Drive 99 wraps then one more -> wrap counter 00, idx3 blank, idx2 seg=1000000.
REQ-029 Change count_in mid-scan (idx=1) from 5 to 7 -> idx2/idx3 of current scan unaffected; next scan idx0 seg=1111000.
REQ-030 Assert rst_n=0 for 1 cycle at idx=2 after 5 wraps -> outputs all-off during reset; wrap counter 00; scan restarts at an=1110.

Source files
------------

// File: rtl/count_seg7_display.sv
// Four-digit multiplexed seven-segment driver: shows the 4-bit count in decimal and
// a 2-digit BCD count of 15->0 wraps, refreshed from a per-scan snapshot.
module count_seg7_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] count_in,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);

  logic [DW-1:0] div_r;
  logic [1:0]    idx_r;
  logic          first_r;
  logic [3:0]    cnt_q_r, cnt_prev_r;
  logic [3:0]    wrap_tens_r, wrap_ones_r;
  logic [3:0]    snap_ct_r, snap_co_r, snap_wt_r, snap_wo_r;

  logic          wrap_s, tick_s, snap_s, blank_s;
  logic [3:0]    cnt_tens_s, cnt_ones_s, digit_s;
  logic [6:0]    seg_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign wrap_s     = (cnt_prev_r == 4'd15) && (cnt_q_r == 4'd0);
  assign tick_s     = (div_r == DIV_LAST);
  assign snap_s     = first_r || (tick_s && (idx_r == 2'd3));
  assign cnt_tens_s = (cnt_q_r >= 4'd10) ? 4'd1 : 4'd0;
  assign cnt_ones_s = (cnt_q_r >= 4'd10) ? (cnt_q_r - 4'd10) : cnt_q_r;

  // Select the snapshot digit for the current scan position, with leading-zero blanking
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b0;
    case (idx_r)
      2'd0: digit_s = snap_co_r;
      2'd1: begin
        digit_s = snap_ct_r;
        blank_s = (snap_ct_r == 4'd0);
      end
      2'd2: digit_s = snap_wo_r;
      2'd3: begin
        digit_s = snap_wt_r;
        blank_s = (snap_wt_r == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
      end
    endcase
    if (blank_s) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg7(digit_s);
    end
  end

  // Sampling, wrap counting, refresh scan, snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r       <= '0;
      idx_r       <= 2'd0;
      first_r     <= 1'b1;
      cnt_q_r     <= 4'd0;
      cnt_prev_r  <= 4'd0;
      wrap_tens_r <= 4'd0;
      wrap_ones_r <= 4'd0;
      snap_ct_r   <= 4'd0;
      snap_co_r   <= 4'd0;
      snap_wt_r   <= 4'd0;
      snap_wo_r   <= 4'd0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
    end else begin
      cnt_q_r    <= count_in;
      cnt_prev_r <= cnt_q_r;
      first_r    <= 1'b0;
      if (tick_s) begin
        div_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        div_r <= div_r + DW'(1);
      end
      // Snapshot sees the wrap counter before any increment on this same edge
      if (snap_s) begin
        snap_ct_r <= cnt_tens_s;
        snap_co_r <= cnt_ones_s;
        snap_wt_r <= wrap_tens_r;
        snap_wo_r <= wrap_ones_r;
      end
      if (wrap_s) begin
        if (wrap_ones_r == 4'd9) begin
          wrap_ones_r <= 4'd0;
          wrap_tens_r <= (wrap_tens_r == 4'd9) ? 4'd0 : (wrap_tens_r + 4'd1);
        end else begin
          wrap_ones_r <= wrap_ones_r + 4'd1;
        end
      end
      an  <= ~(4'b0001 << idx_r);
      seg <= seg_s;
      dp  <= (idx_r == 2'd2) ? 1'b0 : 1'b1;
    end
  end

endmodule
